rv32i_mem_arbiter: RTL and testbench

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

---
 rtl/rv32i_mem_arbiter.sv | 112 +++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// Shared-memory arbiter for an RV32I core: an instruction-fetch port and a data
// port take turns on one memory port, with exactly one transaction in flight.
module rv32i_mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int SW = ($clog2(MAX_DSTREAK + 1) > 3) ? $clog2(MAX_DSTREAK + 1) : 3;
    localparam int WW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_t;

    state_t        state;
    logic [SW-1:0] dstreak;
    logic [WW-1:0] wait_cnt;
    logic          data_wins;
    logic          finish;

    // Data normally has priority; a saturated streak hands the port to a waiting fetch.
    assign data_wins = d_req && !(if_req && (dstreak == SW'(MAX_DSTREAK)));
    assign finish    = mem_ready || (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dstreak   <= '0;
            wait_cnt  <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_wins) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_wstrb <= d_wstrb;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        wait_cnt  <= '0;
                        if (if_req && (dstreak < SW'(MAX_DSTREAK))) begin
                            dstreak <= dstreak + 1'b1;
                        end
                    end else if (if_req) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                        dstreak   <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A timed-out transaction still acks, but with zeroed read data and err.
                    if (finish) begin
                        state     <= ACK;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        err       <= !mem_ready;
                        if (state == BUSY_I) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_ready ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: expected transactions are queued when
// requests are driven and checked when the memory port and acks respond.
module tb_rv32i_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          lat;
        bit          ok;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        if_ack;
        logic        d_ack;
        logic        err;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } obs_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    rv32i_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic issue(input exp_t e);
        if (e.is_d) begin
            d_req   = 1'b1;
            d_we    = e.we;
            d_addr  = e.addr;
            d_wdata = e.wdata;
            d_wstrb = e.wstrb;
        end else begin
            if_req  = 1'b1;
            if_addr = e.addr;
        end
        exp_q.push_back(e);
    endtask

    // Memory model: waits for mem_req, inserts wait states, then returns data.
    task automatic mem_serve(input int waits, input logic [31:0] data, output obs_t o);
        o = '{default: '0};
        do begin
            @(negedge clk);
            o.lat++;
        end while (mem_req !== 1'b1 && o.lat < 20);
        if (mem_req !== 1'b1) return;
        o.ok    = 1'b1;
        o.addr  = mem_addr;
        o.we    = mem_we;
        o.wstrb = mem_wstrb;
        o.wdata = mem_wdata;
        for (int w = 0; w < waits; w++) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_rdata  = $urandom;
        o.if_ack   = if_ack;
        o.d_ack    = d_ack;
        o.err      = err;
        o.if_rdata = if_rdata;
        o.d_rdata  = d_rdata;
    endtask

    task automatic test_reset;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0; mem_ready = 1'b0;
        #1 reset = 1'b1;
        #2;
        tests_run++;
        if ({mem_req, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_ack, d_ack, err});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_memport: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb});
        end
        tests_run++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch;
        exp_t e;
        obs_t o;
        @(negedge clk);
        issue('{is_d: 1'b0, addr: 32'h100, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h13, err: 1'b0});
        mem_serve(0, exp_q[0].rdata, o);
        e = exp_q.pop_front();
        if_req = 1'b0;
        tests_run++;
        if (!o.ok || {o.addr, o.we, o.wstrb} !== {e.addr, e.we, e.wstrb}) begin
            tests_failed++;
            $display("[TB] FAIL fetch_port: got ok=%0d %h/%b/%h expected %h/%b/%h", o.ok, o.addr, o.we, o.wstrb, e.addr, e.we, e.wstrb);
        end
        tests_run++;
        if ({o.d_ack, o.if_ack, o.err} !== {e.is_d, ~e.is_d, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL fetch_ack: got %b expected %b", {o.d_ack, o.if_ack, o.err}, {e.is_d, ~e.is_d, e.err});
        end
        tests_run++;
        if (o.if_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL fetch_rdata: got %h expected %h", o.if_rdata, e.rdata);
        end
        tests_run++;
        if (o.lat !== 1) begin
            tests_failed++;
            $display("[TB] FAIL fetch_latency: got %0d expected 1", o.lat);
        end
        @(negedge clk);
        tests_run++;
        if ({if_ack, mem_req, err} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL fetch_ack_pulse: got %b expected 000", {if_ack, mem_req, err});
        end
    endtask

    task automatic test_ready_idle;
        mem_rdata = 32'hFFFF_FFFF;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({mem_req, if_ack, d_ack, err} !== 4'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle_ready_ignored: got %b expected 0000", {mem_req, if_ack, d_ack, err});
            end
        end
        mem_ready = 1'b0;
        tests_run++;
        if ({if_rdata, d_rdata} !== {32'h13, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL idle_rdata_hold: got %h expected %h", {if_rdata, d_rdata}, {32'h13, 32'h0});
        end
    endtask

    task automatic test_priority;
        exp_t e;
        obs_t o;
        @(negedge clk);
        issue('{is_d: 1'b1, addr: 32'h2000, we: 1'b1, wstrb: 4'hF, wdata: 32'hDEAD_BEEF, rdata: 32'h0BAD_0BAD, err: 1'b0});
        issue('{is_d: 1'b0, addr: 32'h300, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h93, err: 1'b0});
        for (int i = 0; i < 2; i++) begin
            mem_serve(0, exp_q[0].rdata, o);
            e = exp_q.pop_front();
            if (o.d_ack) d_req = 1'b0;
            if (o.if_ack) if_req = 1'b0;
            tests_run++;
            if (!o.ok || {o.addr, o.we, o.wstrb} !== {e.addr, e.we, e.wstrb}) begin
                tests_failed++;
                $display("[TB] FAIL prio_port[%0d]: got ok=%0d %h/%b/%h expected %h/%b/%h", i, o.ok, o.addr, o.we, o.wstrb, e.addr, e.we, e.wstrb);
            end
            if (e.we) begin
                tests_run++;
                if (o.wdata !== e.wdata) begin
                    tests_failed++;
                    $display("[TB] FAIL prio_wdata[%0d]: got %h expected %h", i, o.wdata, e.wdata);
                end
            end
            tests_run++;
            if ({o.d_ack, o.if_ack, o.err} !== {e.is_d, ~e.is_d, e.err}) begin
                tests_failed++;
                $display("[TB] FAIL prio_ack[%0d]: got %b expected %b", i, {o.d_ack, o.if_ack, o.err}, {e.is_d, ~e.is_d, e.err});
            end
            tests_run++;
            if ((e.is_d ? o.d_rdata : o.if_rdata) !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL prio_rdata[%0d]: got %h expected %h", i, e.is_d ? o.d_rdata : o.if_rdata, e.rdata);
            end
        end
    endtask

    // Both requesters held: four data grants, then the starved fetch, repeating.
    task automatic test_back_to_back;
        exp_t e;
        obs_t o;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = '0; d_wstrb = '0;
        if_req = 1'b1; if_addr = 32'h700;
        for (int i = 0; i < 10; i++) begin
            e.is_d  = (i % 5) != 4;
            e.addr  = e.is_d ? 32'h44 : 32'h700;
            e.we    = 1'b0;
            e.wstrb = 4'h0;
            e.wdata = 32'h0;
            e.rdata = 32'h1000 + 32'(i);
            e.err   = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            mem_serve(0, exp_q[0].rdata, o);
            e = exp_q.pop_front();
            tests_run++;
            if ({o.ok, o.d_ack, o.if_ack, o.addr} !== {1'b1, e.is_d, ~e.is_d, e.addr}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_grant[%0d]: got ok=%0d d=%b i=%b %h expected d=%b %h", i, o.ok, o.d_ack, o.if_ack, o.addr, e.is_d, e.addr);
            end
            tests_run++;
            if ((e.is_d ? o.d_rdata : o.if_rdata) !== e.rdata) begin
                tests_failed++;
                $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", i, e.is_d ? o.d_rdata : o.if_rdata, e.rdata);
            end
            tests_run++;
            if (o.lat !== ((i == 0) ? 1 : 2)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", i, o.lat, (i == 0) ? 1 : 2);
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
    endtask

    task automatic test_timeout;
        exp_t e;
        int   busy = 0;
        @(negedge clk);
        issue('{is_d: 1'b0, addr: 32'h500, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h0, err: 1'b1});
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1) busy++;
            if (if_ack === 1'b1 || d_ack === 1'b1) break;
        end
        e = exp_q.pop_front();
        if_req = 1'b0;
        tests_run++;
        if ({d_ack, if_ack, err} !== {e.is_d, ~e.is_d, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_ack: got %b expected %b", {d_ack, if_ack, err}, {e.is_d, ~e.is_d, e.err});
        end
        tests_run++;
        if (busy !== 255) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycles: got %0d expected 255", busy);
        end
        tests_run++;
        if (if_rdata !== e.rdata) begin
            tests_failed++;
            $display("[TB] FAIL timeout_rdata: got %h expected %h", if_rdata, e.rdata);
        end
        @(negedge clk);
        tests_run++;
        if ({if_ack, err, mem_req} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_idle: got %b expected 000", {if_ack, err, mem_req});
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        obs_t o;
        int   k;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0; d_wstrb = '0;
        for (k = 0; k < 10 && mem_req !== 1'b1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({mem_req, d_ack, err, mem_addr, d_rdata} !== 67'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async: got req=%b ack=%b err=%b addr=%h rdata=%h expected all 0", mem_req, d_ack, err, mem_addr, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({d_ack, if_ack, err} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_noack: got %b expected 000", {d_ack, if_ack, err});
        end
        reset = 1'b0;
        issue('{is_d: 1'b1, addr: 32'h84, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h5A5A_1234, err: 1'b0});
        mem_serve(3, exp_q[0].rdata, o);
        e = exp_q.pop_front();
        d_req = 1'b0;
        tests_run++;
        if ({o.ok, o.addr, o.we, o.d_ack, o.if_ack, o.err} !== {1'b1, e.addr, e.we, e.is_d, ~e.is_d, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next: got ok=%0d %h we=%b ack=%b%b err=%b expected %h", o.ok, o.addr, o.we, o.d_ack, o.if_ack, o.err, e.addr);
        end
        tests_run++;
        if ({o.d_rdata, o.lat} !== {e.rdata, 32'd1}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_rdata: got %h lat=%0d expected %h lat=1", o.d_rdata, o.lat, e.rdata);
        end
    endtask

    task automatic test_hold_rdata;
        exp_t e;
        obs_t o;
        issue('{is_d: 1'b1, addr: 32'h40, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'hCAFE_F00D, err: 1'b0});
        mem_serve(2, exp_q[0].rdata, o);
        e = exp_q.pop_front();
        d_req = 1'b0;
        tests_run++;
        if ({o.ok, o.d_ack, o.d_rdata} !== {1'b1, 1'b1, e.rdata}) begin
            tests_failed++;
            $display("[TB] FAIL hold_load: got ok=%0d ack=%b rdata=%h expected %h", o.ok, o.d_ack, o.d_rdata, e.rdata);
        end
        issue('{is_d: 1'b0, addr: 32'h600, we: 1'b0, wstrb: 4'h0, wdata: 32'h0, rdata: 32'h1111_1111, err: 1'b0});
        mem_serve(0, exp_q[0].rdata, o);
        e = exp_q.pop_front();
        if_req = 1'b0;
        tests_run++;
        if ({o.ok, o.if_ack, o.if_rdata} !== {1'b1, 1'b1, e.rdata}) begin
            tests_failed++;
            $display("[TB] FAIL hold_fetch: got ok=%0d ack=%b rdata=%h expected %h", o.ok, o.if_ack, o.if_rdata, e.rdata);
        end
        tests_run++;
        if (o.d_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("[TB] FAIL hold_drdata: got %h expected cafef00d", o.d_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_ready_idle();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_hold_rdata();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
